tmr_cnt_core: RTL and testbench
===============================

// Module: tmr_cnt_core
// PURPOSE
//  Parametrised timer counter core. Selects one of N external tick sources and
//  counts its rising edges (synchronised to pclk) up or down. Supports sync load
//  and auto-reload. Raises sticky overflow, underflow and compare-match flags.
//  Sits between the APB register file (ctrl/tdr/cmp/clear) and the interrupt logic.
// PARAMETERS
//  WIDTH    8  counter / load / compare width in bits (>=2)
//  NSRC     4  number of tick sources (>=1)
//  SELW     2  width of cks; must satisfy 2**SELW >= NSRC
// PORTS
//  pclk         in   1      system clock, all logic on rising edge
//  presetn      in   1      async active-low reset
//  tick_src     in   NSRC   tick sources, already synchronous to pclk
//  cks          in   SELW   tick source select; values >= NSRC select no source
//  en           in   1      count enable
//  ud           in   1      direction: 0 = up, 1 = down
//  arl          in   1      auto-reload mode enable
//  load         in   1      sync load pulse: cnt <= tdr
//  tdr          in   WIDTH  load / reload value
//  cmp_val      in   WIDTH  compare value
//  clr_trig     in   3      sticky clear: [0] ovf, [1] udf, [2] cmp
//  cnt          out  WIDTH  current count
//  count_enable out  1      combinational tick qualifier for this cycle
//  ovf_trig     out  1      sticky overflow flag
//  udf_trig     out  1      sticky underflow flag
//  cmp_trig     out  1      sticky compare-match flag
// BEHAVIOUR
//  Reset: last_src = 0 (all bits); cnt = 0; ovf_trig = udf_trig = cmp_trig = 0.
//  Edge detect: one last_src bit per source, updated every pclk from tick_src.
//    All bits track continuously, so a change of cks never makes a false tick
//    from stale history.
//  count_enable = en & tick_src[cks] & ~last_src[cks] (0 when cks >= NSRC).
//    Pure combinational; the count update lands on the same pclk edge (1 cycle).
//  Counter priority, per pclk edge:
//    1. load = 1                  -> cnt <= tdr; no flag set; ignores en/tick
//    2. count_enable, up, cnt=MAX -> cnt <= arl ? tdr : 0; set ovf_trig
//    3. count_enable, dn, cnt=0   -> cnt <= arl ? tdr : MAX; set udf_trig
//    4. count_enable              -> cnt <= cnt +/- 1, modulo 2**WIDTH
//    5. otherwise                 -> hold
//    MAX = 2**WIDTH-1.
//  Compare: set cmp_trig on an edge where a count step (cases 2-4) makes the
//    next cnt equal cmp_val. Load never sets cmp_trig. Holding at cmp_val does
//    not re-set it.
//  Flags: sticky until the matching clr_trig bit is high.
//    Clear in the same cycle as a set event: clear wins, flag ends 0.
//    One clr bit clears only its own flag.
//  Changing ud or arl between ticks is allowed; it takes effect on the next tick.
//  Reset mid-count: asserting presetn low forces reset values at once, async.
//    First tick after release needs a 0->1 edge seen after reset.
// TESTING
//  T1 WIDTH=8, cks=0, ud=0, en=1, cnt=0, 256 rising edges on src0
//     -> cnt back to 0x00; ovf_trig=1 after edge 256; udf_trig=0.
//  T2 ud=1, arl=1, tdr=0x10, load, then 17 ticks
//     -> cnt 0x10..0x00, then tick 17 gives cnt=0x10 and udf_trig=1.
//  T3 ovf set event and clr_trig=3'b001 in the same cycle
//     -> ovf_trig stays 0; with clr=3'b010 instead, ovf_trig=1.
//  T4 load=1 and tick together, tdr=0x55 -> cnt=0x55, no flags.
//     cmp_val=0x56, next tick -> cnt=0x56, cmp_trig=1.
//  T5 src1 held high, cks switched 0->1 -> no tick.
//     cks=3 with NSRC=3 -> count_enable stays 0 on all toggles.
//  T6 WIDTH=16, async reset pulse mid-count at cnt=0x1234
//     -> cnt=0 and all flags 0 immediately; counting resumes on next src edge.

Source files
------------

// File: rtl/tmr_cnt_core.sv
// Timer counter core: selects one of NSRC tick sources, counts its rising edges up or down
// with sync load, auto-reload and sticky overflow/underflow/compare flags.
module tmr_cnt_core #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NSRC  = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic [NSRC-1:0]  tick_src,
    input  logic [SELW-1:0]  cks,
    input  logic             en,
    input  logic             ud,
    input  logic             arl,
    input  logic             load,
    input  logic [WIDTH-1:0] tdr,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic [2:0]       clr_trig,
    output logic [WIDTH-1:0] cnt,
    output logic             count_enable,
    output logic             ovf_trig,
    output logic             udf_trig,
    output logic             cmp_trig
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [NSRC-1:0]  last_src_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             cmp_q, cmp_d;
    logic             src_rise;
    logic             step;
    logic             ovf_set, udf_set, cmp_set;

    // Out-of-range selects match no source, so src_rise stays 0.
    always_comb begin
        src_rise = 1'b0;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (cks == SELW'(i)) begin
                src_rise = tick_src[i] & ~last_src_q[i];
            end
        end
    end

    assign count_enable = en & src_rise;

    always_comb begin
        cnt_d   = cnt_q;
        step    = 1'b0;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (load) begin
            cnt_d = tdr;
        end else if (count_enable) begin
            step = 1'b1;
            if (!ud) begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = arl ? tdr : '0;
                    ovf_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d   = arl ? tdr : CNT_MAX;
                    udf_set = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
        cmp_set = step && (cnt_d == cmp_val);
    end

    // Clear has priority over a same-cycle set.
    always_comb begin
        ovf_d = clr_trig[0] ? 1'b0 : (ovf_q | ovf_set);
        udf_d = clr_trig[1] ? 1'b0 : (udf_q | udf_set);
        cmp_d = clr_trig[2] ? 1'b0 : (cmp_q | cmp_set);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            last_src_q <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            cmp_q      <= 1'b0;
        end else begin
            last_src_q <= tick_src;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            cmp_q      <= cmp_d;
        end
    end

    assign cnt      = cnt_q;
    assign ovf_trig = ovf_q;
    assign udf_trig = udf_q;
    assign cmp_trig = cmp_q;

endmodule

// File: tb/tb_tmr_cnt_core.sv
// Directed bench for tmr_cnt_core: an 8-bit/3-source instance and a 16-bit/4-source instance.
module tb_tmr_cnt_core;

    logic        pclk = 1'b0;
    logic        presetn;
    logic [2:0]  tick_src;
    logic [1:0]  cks;
    logic        en, ud, arl, load;
    logic [7:0]  tdr, cmp_val;
    logic [2:0]  clr_trig;
    logic [7:0]  cnt;
    logic        count_enable, ovf_trig, udf_trig, cmp_trig;

    logic        presetn16;
    logic [3:0]  tick_src16;
    logic [1:0]  cks16;
    logic        en16, ud16, arl16, load16;
    logic [15:0] tdr16, cmp_val16;
    logic [2:0]  clr_trig16;
    logic [15:0] cnt16;
    logic        count_enable16, ovf16, udf16, cmp16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 pclk = ~pclk;

    tmr_cnt_core #(.WIDTH(8), .NSRC(3), .SELW(2)) u_dut (
        .pclk(pclk), .presetn(presetn), .tick_src(tick_src), .cks(cks), .en(en), .ud(ud),
        .arl(arl), .load(load), .tdr(tdr), .cmp_val(cmp_val), .clr_trig(clr_trig), .cnt(cnt),
        .count_enable(count_enable), .ovf_trig(ovf_trig), .udf_trig(udf_trig),
        .cmp_trig(cmp_trig)
    );

    tmr_cnt_core #(.WIDTH(16), .NSRC(4), .SELW(2)) u_dut16 (
        .pclk(pclk), .presetn(presetn16), .tick_src(tick_src16), .cks(cks16), .en(en16),
        .ud(ud16), .arl(arl16), .load(load16), .tdr(tdr16), .cmp_val(cmp_val16),
        .clr_trig(clr_trig16), .cnt(cnt16), .count_enable(count_enable16), .ovf_trig(ovf16),
        .udf_trig(udf16), .cmp_trig(cmp16)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic tick();
        tick_src[0] = 1'b1;
        cyc();
        tick_src[0] = 1'b0;
        cyc();
    endtask

    task automatic tick16();
        tick_src16[0] = 1'b1;
        cyc();
        tick_src16[0] = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        presetn = 1'b0; tick_src = '0; cks = 2'd0; en = 1'b0; ud = 1'b0; arl = 1'b0;
        load = 1'b0; tdr = '0; cmp_val = 8'h80; clr_trig = '0;
        cyc(); cyc();
        n_cmp++;
        if (cnt !== 8'h00) begin
            n_bad++; $display("FAIL reset_cnt: got %h want 00", cnt);
        end
        n_cmp++;
        if ({ovf_trig, udf_trig, cmp_trig} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000", {ovf_trig, udf_trig, cmp_trig});
        end
        presetn = 1'b1;
        cyc();
    endtask

    task automatic test_ovf_wrap();
        en = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        n_cmp++;
        if (cnt !== 8'hFF || ovf_trig !== 1'b0) begin
            n_bad++; $display("FAIL t1_pre_wrap: got cnt=%h ovf=%b want ff 0", cnt, ovf_trig);
        end
        tick();
        n_cmp++;
        if (cnt !== 8'h00) begin
            n_bad++; $display("FAIL t1_wrap_cnt: got %h want 00", cnt);
        end
        n_cmp++;
        if (ovf_trig !== 1'b1 || udf_trig !== 1'b0) begin
            n_bad++; $display("FAIL t1_flags: got ovf=%b udf=%b want 1 0", ovf_trig, udf_trig);
        end
        n_cmp++;
        if (cmp_trig !== 1'b1) begin
            n_bad++; $display("FAIL t1_cmp_0x80: got %b want 1", cmp_trig);
        end
    endtask

    task automatic test_udf_reload();
        clr_trig = 3'b111; cyc(); clr_trig = 3'b000;
        ud = 1'b1; arl = 1'b1; tdr = 8'h10; cmp_val = 8'h05;
        load = 1'b1; cyc(); load = 1'b0;
        n_cmp++;
        if (cnt !== 8'h10) begin
            n_bad++; $display("FAIL t2_load: got %h want 10", cnt);
        end
        for (int i = 0; i < 8; i++) tick();
        n_cmp++;
        if (cnt !== 8'h08) begin
            n_bad++; $display("FAIL t2_mid: got %h want 08", cnt);
        end
        for (int i = 0; i < 8; i++) tick();
        n_cmp++;
        if (cnt !== 8'h00 || udf_trig !== 1'b0) begin
            n_bad++; $display("FAIL t2_zero: got cnt=%h udf=%b want 00 0", cnt, udf_trig);
        end
        tick();
        n_cmp++;
        if (cnt !== 8'h10 || udf_trig !== 1'b1) begin
            n_bad++; $display("FAIL t2_reload: got cnt=%h udf=%b want 10 1", cnt, udf_trig);
        end
        n_cmp++;
        if (cmp_trig !== 1'b1 || ovf_trig !== 1'b0) begin
            n_bad++; $display("FAIL t2_other_flags: got cmp=%b ovf=%b want 1 0", cmp_trig, ovf_trig);
        end
    endtask

    task automatic test_clr_same_cycle();
        // udf and cmp are set from the previous test; clearing ovf must not touch them.
        ud = 1'b0; arl = 1'b0; tdr = 8'hFF;
        clr_trig = 3'b001; load = 1'b1; cyc(); clr_trig = 3'b000; load = 1'b0;
        n_cmp++;
        if ({udf_trig, cmp_trig} !== 2'b11) begin
            n_bad++; $display("FAIL t3_own_bit: got udf,cmp=%b want 11", {udf_trig, cmp_trig});
        end
        tick_src[0] = 1'b1; clr_trig = 3'b001; cyc();
        tick_src[0] = 1'b0; clr_trig = 3'b000; cyc();
        n_cmp++;
        if (ovf_trig !== 1'b0 || cnt !== 8'h00) begin
            n_bad++; $display("FAIL t3_clr_wins: got ovf=%b cnt=%h want 0 00", ovf_trig, cnt);
        end
        load = 1'b1; cyc(); load = 1'b0;
        tick_src[0] = 1'b1; clr_trig = 3'b010; cyc();
        tick_src[0] = 1'b0; clr_trig = 3'b000; cyc();
        n_cmp++;
        if (ovf_trig !== 1'b1 || udf_trig !== 1'b0) begin
            n_bad++; $display("FAIL t3_other_clr: got ovf=%b udf=%b want 1 0", ovf_trig, udf_trig);
        end
    endtask

    task automatic test_load_priority();
        clr_trig = 3'b111; cyc(); clr_trig = 3'b000;
        tdr = 8'h55; cmp_val = 8'h55;
        load = 1'b1; tick_src[0] = 1'b1; cyc();
        load = 1'b0; tick_src[0] = 1'b0; cyc();
        n_cmp++;
        if (cnt !== 8'h55) begin
            n_bad++; $display("FAIL t4_load_cnt: got %h want 55", cnt);
        end
        n_cmp++;
        if ({ovf_trig, udf_trig, cmp_trig} !== 3'b000) begin
            n_bad++; $display("FAIL t4_load_flags: got %b want 000", {ovf_trig, udf_trig, cmp_trig});
        end
        cmp_val = 8'h56;
        tick();
        n_cmp++;
        if (cnt !== 8'h56 || cmp_trig !== 1'b1) begin
            n_bad++; $display("FAIL t4_cmp: got cnt=%h cmp=%b want 56 1", cnt, cmp_trig);
        end
        clr_trig = 3'b100; cyc(); clr_trig = 3'b000;
        en = 1'b0;
        tick(); tick();
        n_cmp++;
        if (cnt !== 8'h56 || cmp_trig !== 1'b0) begin
            n_bad++; $display("FAIL t4_hold: got cnt=%h cmp=%b want 56 0", cnt, cmp_trig);
        end
        en = 1'b1;
    endtask

    task automatic test_src_select();
        tick_src = 3'b010; cks = 2'd0;
        cyc(); cyc();
        cks = 2'd1; #1;
        n_cmp++;
        if (count_enable !== 1'b0) begin
            n_bad++; $display("FAIL t5_switch_ce: got %b want 0", count_enable);
        end
        cyc();
        n_cmp++;
        if (cnt !== 8'h56) begin
            n_bad++; $display("FAIL t5_switch_cnt: got %h want 56", cnt);
        end
        tick_src[1] = 1'b0; cyc();
        tick_src[1] = 1'b1; #1;
        n_cmp++;
        if (count_enable !== 1'b1) begin
            n_bad++; $display("FAIL t5_src1_ce: got %b want 1", count_enable);
        end
        cyc(); cyc(); cyc();
        n_cmp++;
        if (cnt !== 8'h57) begin
            n_bad++; $display("FAIL t5_level_once: got %h want 57", cnt);
        end
        cks = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick_src = 3'b000; cyc();
            tick_src = 3'b111; #1;
            n_cmp++;
            if (count_enable !== 1'b0) begin
                n_bad++; $display("FAIL t5_cks3_ce[%0d]: got %b want 0", i, count_enable);
            end
            cyc();
        end
        n_cmp++;
        if (cnt !== 8'h57) begin
            n_bad++; $display("FAIL t5_cks3_cnt: got %h want 57", cnt);
        end
        tick_src = 3'b000;
    endtask

    task automatic test_async_reset16();
        cks16 = 2'd0; en16 = 1'b1; ud16 = 1'b0; arl16 = 1'b0;
        tdr16 = 16'h1230; cmp_val16 = 16'h1234;
        load16 = 1'b1; cyc(); load16 = 1'b0;
        for (int i = 0; i < 4; i++) tick16();
        n_cmp++;
        if (cnt16 !== 16'h1234 || cmp16 !== 1'b1) begin
            n_bad++; $display("FAIL t6_pre: got cnt=%h cmp=%b want 1234 1", cnt16, cmp16);
        end
        #2 presetn16 = 1'b0;
        #1;
        n_cmp++;
        if (cnt16 !== 16'h0000 || {ovf16, udf16, cmp16} !== 3'b000) begin
            n_bad++; $display("FAIL t6_async: got cnt=%h flags=%b want 0000 000",
                              cnt16, {ovf16, udf16, cmp16});
        end
        cyc();
        presetn16 = 1'b1;
        cyc();
        tick16();
        n_cmp++;
        if (cnt16 !== 16'h0001) begin
            n_bad++; $display("FAIL t6_resume: got %h want 0001", cnt16);
        end
    endtask

    initial begin
        presetn16 = 1'b0; tick_src16 = '0; cks16 = '0; en16 = 1'b0; ud16 = 1'b0;
        arl16 = 1'b0; load16 = 1'b0; tdr16 = '0; cmp_val16 = '0; clr_trig16 = '0;
        test_reset();
        presetn16 = 1'b1;
        test_ovf_wrap();
        test_udf_reload();
        test_clr_same_cycle();
        test_load_priority();
        test_src_select();
        test_async_reset16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
